uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver on the FPGA side of the board's serial link; consumes the host TX line (uart_txd_in) driven by the bench UART model or the USB-UART bridge.
- Recovers 8N1 frames with 16x oversampling and mid-bit sampling.
- Buffers received bytes in a small first-word-fall-through FIFO, read by the fmrv32im peripheral bus logic through a valid/ready handshake.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 16, byte entries; power of two, 2..256.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RXD  input  1  serial line; asynchronous; idle high.
- RDATA  output  8  byte at FIFO head; valid only while RVALID=1.
- RVALID  output  1  FIFO not empty.
- RREADY  input  1  consumer pops the head when RVALID&RREADY at a rising edge.
- FIFO_COUNT  output  $clog2(FIFO_DEPTH)+1  number of stored bytes.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  output  1  one-cycle pulse: byte dropped because FIFO full.

Behaviour:
- Reset (async assert, sync release): synchroniser flops=1, state=IDLE, FIFO empty, RVALID=0, RDATA=0, FIFO_COUNT=0, FRAME_ERR=0, OVERRUN=0.
- RXD passes through a 2-flop synchroniser (reset value 1). All decisions use the synchronised value rxs.
- Oversample tick: DIV=CLK_FREQ/(BAUD*16), integer division; defaults give 54, i.e. 864 clocks/bit, -0.47% error.
  - The divider counter runs 0..DIV-1. It is cleared in IDLE and restarts when a start edge is detected.
  - The phase counter (0..15) advances once per tick.
- States:
  - IDLE: rxs==0 -> START, with divider and phase cleared.
  - START: at phase 7 (mid-bit), rxs==1 -> false start, back to IDLE with no error; otherwise -> DATA with bit index 0, phase wrapping 15->0.
  - DATA: sample at each phase 7 into a shift register, LSB first. After bit 7 -> STOP.
  - STOP: sample at phase 7, then go straight to IDLE in the same cycle, without waiting out the second half of the stop bit; this allows resync to back-to-back frames.
    - Sample 1 -> push byte.
    - Sample 0 -> FRAME_ERR pulse on the next cycle; byte discarded. IDLE then waits for rxs==1 before re-arming start detection, so a break does not retrigger.
- Push latency: byte visible at RDATA with RVALID=1 on the cycle after the stop-bit sample when the FIFO was empty. Roughly 9.5 bit times after the start edge, about 8210 clocks at defaults.
- FIFO: circular buffer; pointers wrap modulo FIFO_DEPTH.
  - RDATA always shows the head entry.
  - RVALID = (FIFO_COUNT != 0).
  - Pop while empty is ignored.
- Push while full:
  - With a pop in the same cycle: push accepted, FIFO_COUNT unchanged, no OVERRUN.
  - Without a pop: byte dropped, OVERRUN pulses 1 cycle, contents unchanged.
- Simultaneous push and pop when not full: FIFO_COUNT unchanged, both take effect.
- Reset mid-frame: the partial frame is lost and the FIFO is cleared. Reception resumes at the next falling edge after release; a line already low at release is treated as a start edge.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample (start validation, data, stop) is a 2-of-3 majority of rxs at phases 6, 7 and 8; the decision is taken at phase 8. Single-clock glitches inside a bit are rejected.
- Undefined: single sample at phase 7 as described above. No extra flops.

Test Plan:
- Bench UART sends 0x65 ('e') at 115200, RREADY=0 -> RVALID rises about 8210 clocks after the start edge; RDATA=0x65, FIFO_COUNT=1. Pulse RREADY for one cycle -> RVALID=0, FIFO_COUNT=0.
- Send "echoback\r\n" back-to-back with RREADY=1 -> 10 bytes in order 0x65 0x63 0x68 0x6F 0x62 0x61 0x63 0x6B 0x0D 0x0A; no FRAME_ERR or OVERRUN.
- RXD low for 2 us, then high -> no push, FRAME_ERR=0, state back in IDLE. Then send 0xA5 -> RDATA=0xA5.
- Frame 0x3C with stop bit forced low -> FRAME_ERR single-cycle pulse, FIFO_COUNT stays 0. Next valid frame 0x3C -> received.
- With FIFO_DEPTH=16 and RREADY=0, send 17 bytes 0x00..0x10 -> FIFO_COUNT=16, OVERRUN pulse once at the 17th. Reads then return 0x00..0x0F.
- Assert RST_N=0 during bit 4 of a frame, release, send 0x5A -> all outputs are 0 during reset; RDATA=0x5A afterwards; no spurious byte.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// 8N1 UART receiver (16x oversampling, mid-bit sampling) feeding a first-word-fall-through byte FIFO.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at phases 6/7/8.
module uart_rx_fifo #(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         RXD,
   output logic [7:0]                   RDATA,
   output logic                         RVALID,
   input  logic                         RREADY,
   output logic [$clog2(FIFO_DEPTH):0]  FIFO_COUNT,
   output logic                         FRAME_ERR,
   output logic                         OVERRUN
);

   localparam int unsigned DIV   = CLK_FREQ / (BAUD * 16);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t             state_q, state_d;
   logic               rx_meta, rxs;
   logic [DIV_W-1:0]   div_q;
   logic [3:0]         phase_q;
   logic [2:0]         bit_idx_q;
   logic [7:0]         shreg_q;
   logic               tick_c, samp_c, bit_c, push_c, ferr_c;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               pop_c, full_c, wr_c, ovr_c;

   // Two-flop synchroniser for the asynchronous line
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RXD;
         rxs     <= rx_meta;
      end
   end

   assign tick_c = (div_q == DIV_W'(DIV - 1));

   // Oversample divider and phase; held at zero while waiting for a start edge
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_q   <= '0;
         phase_q <= '0;
      end else if (state_q == IDLE || state_q == BRK) begin
         div_q   <= '0;
         phase_q <= '0;
      end else if (tick_c) begin
         div_q   <= '0;
         phase_q <= phase_q + 4'd1;
      end else begin
         div_q   <= div_q + DIV_W'(1);
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic s6_q, s7_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s6_q <= 1'b1;
         s7_q <= 1'b1;
      end else if (tick_c) begin
         if (phase_q == 4'd6) s6_q <= rxs;
         if (phase_q == 4'd7) s7_q <= rxs;
      end
   end

   assign samp_c = tick_c && (phase_q == 4'd8);
   assign bit_c  = (s6_q & s7_q) | (s6_q & rxs) | (s7_q & rxs);
`else
   assign samp_c = tick_c && (phase_q == 4'd7);
   assign bit_c  = rxs;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Frame sequencing; a low stop bit parks in BRK until the line returns high
   always_comb begin
      state_d = state_q;
      push_c  = 1'b0;
      ferr_c  = 1'b0;
      case (state_q)
         IDLE:  if (!rxs) state_d = START;
         START: if (samp_c) state_d = bit_c ? IDLE : DATA;
         DATA:  if (samp_c && bit_idx_q == 3'd7) state_d = STOP;
         STOP:  if (samp_c) begin
                   if (bit_c) begin
                      push_c  = 1'b1;
                      state_d = IDLE;
                   end else begin
                      ferr_c  = 1'b1;
                      state_d = BRK;
                   end
                end
         BRK:   if (rxs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bit_idx_q <= '0;
         shreg_q   <= '0;
      end else if (state_q == START) begin
         bit_idx_q <= '0;
      end else if (state_q == DATA && samp_c) begin
         shreg_q   <= {bit_c, shreg_q[7:1]};
         bit_idx_q <= bit_idx_q + 3'd1;
      end
   end

   assign pop_c  = RREADY && (count_q != '0);
   assign full_c = (count_q == CNT_W'(FIFO_DEPTH));
   assign wr_c   = push_c && (!full_c || pop_c);
   assign ovr_c  = push_c && full_c && !pop_c;

   // Circular buffer; a pop in the same cycle frees room for a push into a full FIFO
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (wr_c) begin
            mem[wr_ptr_q] <= shreg_q;
            wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         FRAME_ERR <= ferr_c;
         OVERRUN   <= ovr_c;
      end
   end

   assign RDATA      = mem[rd_ptr_q];
   assign RVALID     = (count_q != '0);
   assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_fifo: bit-level UART driver, queue-based FIFO model, decoupled monitor.
module tb_uart_rx_fifo;

   localparam int unsigned CLK_FREQ = 100000000;
   localparam int unsigned BAUD     = 1562500;
   localparam int unsigned DEPTH    = 16;
   localparam int          BIT      = int'(CLK_FREQ / BAUD);
   localparam int          LAT_NOM  = 9 * BIT + BIT / 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd = 1'b1;
   logic       rready = 1'b0;
   logic [7:0] rdata;
   logic       rvalid;
   logic [4:0] fifo_count;
   logic       frame_err;
   logic       overrun;

   uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(clk), .RST_N(rst_n), .RXD(rxd), .RDATA(rdata), .RVALID(rvalid),
      .RREADY(rready), .FIFO_COUNT(fifo_count), .FRAME_ERR(frame_err), .OVERRUN(overrun)
   );

   always #5 clk = ~clk;

   int   errors = 0, checks = 0;
   int   cyc = 0, start_cyc = 0, lat = 0;
   int   ferr_seen = 0, ovr_seen = 0, exp_ferr = 0, exp_ovr = 0;
   logic rv_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every handshake pops the model and compares; pulses are counted and width-checked
   always @(negedge clk) begin
      if (rst_n) begin
         if (rvalid && !rv_prev) lat = cyc - start_cyc;
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got 0x%0h expected no byte", rdata);
            end else begin
               check("rdata_pop", int'(rdata), int'(exp_q.pop_front()));
            end
         end
         if (frame_err) begin
            ferr_seen++;
            check("frame_err_width", int'(fe_prev), 0);
         end
         if (overrun) begin
            ovr_seen++;
            check("overrun_width", int'(ov_prev), 0);
         end
      end
      rv_prev = rvalid;
      fe_prev = frame_err;
      ov_prev = overrun;
   end

   // Drives frame bits 0..nbits-1 (start, 8 data LSB first, stop)
   task automatic send(input logic [7:0] b, input logic stop_v, input int nbits, input bit rnd);
      logic [9:0] fr;
      fr = {stop_v, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         for (int k = 0; k < BIT; k++) begin
            @(posedge clk); #1;
            rxd = fr[4'(i)];
            if (i == 0 && k == 0) start_cyc = cyc;
            if (rnd) rready = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // Reference model: a good frame lands in the FIFO unless it is full, a bad stop bit is a frame error
   task automatic send_byte(input logic [7:0] b, input bit good, input bit rnd);
      if (good) begin
         if (exp_q.size() < int'(DEPTH)) exp_q.push_back(b);
         else exp_ovr++;
      end else begin
         exp_ferr++;
      end
      send(b, good, 10, rnd);
   endtask

   task automatic idle(input int n, input bit rnd);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         rxd = 1'b1;
         if (rnd) rready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_state(input string name);
      @(negedge clk);
      check({name, "_count"}, int'(fifo_count), exp_q.size());
      check({name, "_rvalid"}, int'(rvalid), int'(exp_q.size() != 0));
      check({name, "_ferr_total"}, ferr_seen, exp_ferr);
      check({name, "_ovr_total"}, ovr_seen, exp_ovr);
   endtask

   task automatic wait_drain(input string name);
      int n;
      @(posedge clk); #1;
      rready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 4 * int'(DEPTH) + 8) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_left"}, exp_q.size(), 0);
      @(posedge clk); #1;
      rready = 1'b0;
      check_state(name);
   endtask

   task automatic check_reset_outputs(input string name);
      @(negedge clk);
      check({name, "_rvalid"}, int'(rvalid), 0);
      check({name, "_rdata"}, int'(rdata), 0);
      check({name, "_count"}, int'(fifo_count), 0);
      check({name, "_frame_err"}, int'(frame_err), 0);
      check({name, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] msg [10];
      logic [7:0] b;
      bit         good;
      msg = '{8'h65, 8'h63, 8'h68, 8'h6F, 8'h62, 8'h61, 8'h63, 8'h6B, 8'h0D, 8'h0A};

      repeat (3) @(posedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(20, 0);

      // Single byte, latency, single-cycle pop
      send_byte(8'h65, 1, 0);
      idle(8, 0);
      check("latency_in_window", int'(lat >= LAT_NOM - BIT / 4 && lat <= LAT_NOM + BIT / 4), 1);
      check("rdata_first", int'(rdata), 8'h65);
      check_state("first");
      @(posedge clk); #1;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      check_state("after_pulse");

      // Back-to-back frames with consumer always ready
      rready = 1'b1;
      for (int i = 0; i < 10; i++) send_byte(msg[i], 1, 0);
      wait_drain("echoback");

      // False start shorter than half a bit
      @(posedge clk); #1;
      rxd = 1'b0;
      repeat (BIT / 4) @(posedge clk);
      #1;
      rxd = 1'b1;
      idle(2 * BIT, 0);
      check_state("false_start");
      send_byte(8'hA5, 1, 0);
      idle(8, 0);
      check("rdata_a5", int'(rdata), 8'hA5);
      wait_drain("after_false_start");

      // Stop bit low, then a good frame
      send_byte(8'h3C, 0, 0);
      idle(BIT, 0);
      check_state("frame_error");
      send_byte(8'h3C, 1, 0);
      idle(8, 0);
      check("rdata_3c", int'(rdata), 8'h3C);
      wait_drain("after_frame_error");

      // Fill past capacity with no consumer
      for (int i = 0; i <= int'(DEPTH); i++) send_byte(8'(i), 1, 0);
      idle(8, 0);
      check("full_count", int'(fifo_count), int'(DEPTH));
      check_state("overrun");
      wait_drain("overrun_readback");

      // Reset during data bit 4 with a byte already buffered
      send_byte(8'h11, 1, 0);
      idle(8, 0);
      send(8'h77, 1'b1, 5, 0);
      repeat (BIT / 3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      rxd   = 1'b1;
      exp_q.delete();
      check_reset_outputs("mid_frame_reset");
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2 * BIT, 0);
      check_state("post_reset");
      send_byte(8'h5A, 1, 0);
      idle(8, 0);
      check("rdata_5a", int'(rdata), 8'h5A);
      wait_drain("post_reset_read");

      // Random bytes, random stop-bit errors, random gaps and random consumer
      for (int i = 0; i < 12; i++) begin
         b    = 8'($urandom);
         good = ($urandom_range(0, 5) != 0);
         send_byte(b, good, 1);
         idle(int'($urandom_range(0, BIT)), 1);
      end
      wait_drain("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
